// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB3
// transfers (SETUP then ACCESS) with one transfer outstanding at a time,
// and returns one registered response pulse per completed command.
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles with pready low (response carries rsp_err=1, rsp_rdata=0).
module apb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;    // command handshake in IDLE
    logic   done;      // slave completes the ACCESS phase
    logic   timeout;   // ACCESS phase abandoned after the wait limit

    assign accept = (state == S_IDLE) && cmd_valid;
    assign done   = (state == S_ACCESS) && pready;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count ACCESS cycles spent with pready low; cleared while in SETUP so it starts at 0 in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == S_ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The limit is reached on the wait cycle that brings the count to TIMEOUT_CYC; pready wins.
    assign timeout = (state == S_ACCESS) && !pready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the timeout option ACCESS waits forever; the limit only keeps the parameter referenced.
    assign timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic: SETUP always lasts one cycle, ACCESS until pready (or timeout).
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid)          state_nxt = S_SETUP;
            S_SETUP:                          state_nxt = S_ACCESS;
            S_ACCESS: if (pready || timeout)  state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake and APB phase strobes depend on the state only.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            S_IDLE:   cmd_ready = 1'b1;
            S_SETUP:  psel      = 1'b1;
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the command into the APB address/data registers; they hold until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
        end
    end

    // Registered response: one-cycle pulse, data and error hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done || timeout;
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized scoreboard bench for apb_cmd_master. The
// driver pushes an expected response per command; a negedge monitor checks
// APB phases, timing and responses. A behavioural APB slave with a register
// map supplies wait states and errors chosen by the driver.
module tb_apb_cmd_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TCYC   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;   // ACCESS cycles with pready low before the end
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int   waits;
        logic err;
    } slv_cfg_t;

    exp_t        exp_q[$];
    slv_cfg_t    slv_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int b2b_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input bit from_slave);
        if (from_slave) return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Behavioural APB slave: holds pready low for the configured wait count, garbage outside ACCESS.
    bit slv_busy = 1'b0;
    int slv_cnt  = 0;
    always @(negedge clk) begin
        if (psel && penable) begin
            if (!slv_busy) begin
                slv_busy = 1'b1;
                slv_cnt  = 0;
            end
            if (slv_q.size() == 0) begin
                pready = 1'b1; pslverr = 1'b0; prdata = '0;
            end else if (slv_cnt >= slv_q[0].waits) begin
                pready  = 1'b1;
                pslverr = slv_q[0].err;
                prdata  = pwrite ? $urandom : mem_rd(paddr, 1'b1);
                if (pwrite && !slv_q[0].err) slv_mem[paddr] = pwdata;
                slv_q.delete(0);
                slv_busy = 1'b0;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
                slv_cnt++;
            end
        end else begin
            if (slv_busy) begin
                slv_busy = 1'b0;
                slv_q.delete(0);
            end
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    // Monitor: follows the accepted command through SETUP, ACCESS and the response cycle.
    bit   mon_act = 1'b0;
    int   acc_cyc = 0;
    exp_t cur;
    always @(negedge clk) begin
        int d;
        cyc++;
        check("penable_without_psel", 64'(penable && !psel), 64'(0));
        if (mon_act) begin
            cur = exp_q[0];
            d   = cyc - acc_cyc;
            if (d == 1) begin
                check("setup_psel", 64'({psel, penable}), 64'(2'b10));
                check("setup_rsp_valid", 64'(rsp_valid), 64'(0));
                check("setup_paddr", 64'(paddr), 64'(cur.addr));
                check("setup_pwrite", 64'(pwrite), 64'(cur.wr));
                if (cur.wr) check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
            end else if (d <= 2 + cur.waits) begin
                check("access_psel", 64'({psel, penable}), 64'(2'b11));
                check("access_rsp_valid", 64'(rsp_valid), 64'(0));
                check("access_paddr", 64'(paddr), 64'(cur.addr));
                check("access_pwrite", 64'(pwrite), 64'(cur.wr));
                if (cur.wr) check("access_pwdata", 64'(pwdata), 64'(cur.wdata));
            end else begin
                check("rsp_valid", 64'(rsp_valid), 64'(1));
                check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
                check("rsp_err", 64'(rsp_err), 64'(cur.err));
                check("rsp_psel_low", 64'({psel, penable}), 64'(0));
                exp_q.delete(0);
                mon_act = 1'b0;
            end
        end else if (rst_n) begin
            check("no_spurious_rsp", 64'(rsp_valid), 64'(0));
        end
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("accept_without_cmd", 64'(1), 64'(0));
            end else begin
                mon_act = 1'b1;
                acc_cyc = cyc;
                if (rsp_valid) b2b_cnt++;
            end
        end
    end

    // Issue one command. Returns #1 after the accepting edge with cmd_valid still high.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit err, input bit tmo);
        exp_t     e;
        slv_cfg_t s;
        bit       rdy;
        int       budget;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.waits = tmo ? TCYC - 1 : waits;
        e.err   = tmo ? 1'b1 : err;
        e.rdata = (wr || tmo) ? 32'h0 : mem_rd(addr, 1'b0);
        if (wr && !err && !tmo) ref_mem[addr] = wdata;
        s.waits = tmo ? 1000 : waits;
        s.err   = err;
        exp_q.push_back(e);
        slv_q.push_back(s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        budget    = 0;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            budget++;
            if (budget > 2000) begin
                $display("FAIL cmd_handshake: cmd_ready never seen, expected within 2000 cycles");
                $fatal(1, "handshake timeout");
            end
        end while (!rdy);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget = 0;
        cmd_valid = 1'b0;
        while ((exp_q.size() != 0) && (budget < 3000)) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int b2b_before;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_psel", 64'({psel, penable}), 64'(0));
        check("reset_paddr", 64'(paddr), 64'(0));
        check("reset_pwrite_pwdata", 64'({pwrite, pwdata}), 64'(0));
        check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        rst_n = 1'b1;
        idle(2);
        check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        // Directed: write/readback, unwritten register, wait states, slave error.
        issue(1'b1, 32'h4001_0004, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        idle(1);
        issue(1'b0, 32'h4001_0004, 32'h0, 0, 1'b0, 1'b0);
        idle(1);
        issue(1'b0, 32'h4001_0010, 32'h0, 0, 1'b0, 1'b0);
        idle(1);
        issue(1'b0, 32'h4001_0004, 32'h0, 3, 1'b0, 1'b0);
        idle(1);
        issue(1'b1, 32'h4001_0008, 32'h1234_5678, 1, 1'b1, 1'b0);
        issue(1'b1, 32'h4001_0008, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        drain();
        check("slave_reg_0004", 64'(mem_rd(32'h4001_0004, 1'b1)), 64'(32'hDEAD_BEEF));
        check("slave_reg_0008", 64'(mem_rd(32'h4001_0008, 1'b1)), 64'(32'hCAFE_F00D));

`ifdef APB_MST_TIMEOUT_EN
        // Slave never raises pready: the master gives up after TCYC wait cycles.
        issue(1'b0, 32'h4001_000C, 32'h0, 0, 1'b0, 1'b1);
        drain();
`endif

        // Randomized traffic, including back-to-back commands (gap 0).
        for (int i = 0; i < 150; i++) begin
            bit          wr;
            logic [31:0] a;
            int          w;
            wr = 1'($urandom);
            a  = 32'h4001_0000 + 32'(4 * $urandom_range(0, 7));
            w  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            issue(wr, a, $urandom, w, ($urandom_range(0, 4) == 0), 1'b0);
            idle($urandom_range(0, 2));
        end
        drain();

        // Reset in the middle of ACCESS: outputs drop at once and no response follows.
        issue(1'b0, 32'h4001_0014, 32'h0, 6, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_psel", 64'({psel, penable}), 64'(0));
        check("abort_apb_regs", 64'({pwrite, paddr, pwdata}), 64'(0));
        check("abort_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        mon_act = 1'b0;
        exp_q.delete(0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two commands with cmd_valid held: second accepted in the first one's rsp_valid cycle.
        b2b_before = b2b_cnt;
        issue(1'b1, 32'h4001_0018, 32'hA5A5_5A5A, 0, 1'b0, 1'b0);
        issue(1'b0, 32'h4001_0018, 32'h0, 0, 1'b0, 1'b0);
        drain();
        check("b2b_accept_in_rsp_cycle", 64'(b2b_cnt - b2b_before), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
